// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle FSM controller for the 16-bit gigaHurt CPU
module mc_controller #(
    parameter int          n       = 16,
    parameter logic [3:0]  ALU_ADD = 4'b0000,
    parameter logic [3:0]  ALU_SUB = 4'b0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] op,
    input  logic [3:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [3:0] alucontrol,
    output logic       halted,
    output logic       illegal
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, HALT
    } state_t;

    state_t state, state_next;
    logic   illegal_q;
    logic   pcwrite, branch;

    // illegal only records how HALT was entered, so it is set on the DECODE exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE && op == 3'b110)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alucontrol = ALU_ADD;
        unique case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                unique case (op)
                    3'b000:         state_next = RTYPEEX;
                    3'b001, 3'b010: state_next = MEMADR;
                    3'b011:         state_next = BEQEX;
                    3'b100:         state_next = ADDIEX;
                    3'b101:         state_next = JEX;
                    default:        state_next = HALT;
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == 3'b001) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct;
                state_next = RTYPEWB;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                state_next = FETCH;
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign pcen    = pcwrite | (branch & zero);
    assign halted  = (state == HALT);
    assign illegal = illegal_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] op = 3'b000;
    logic [3:0] funct = 4'b0000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       memread, memwrite, iord, irwrite, pcen, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       regdst, memtoreg, regwrite, halted, illegal;
    logic [3:0] alucontrol;
    logic [18:0] outs;

    int tests = 0;
    int fails = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memread(memread), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .pcen(pcen), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alucontrol(alucontrol), .halted(halted),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign outs = {memread, memwrite, iord, irwrite, pcen, alusrca, alusrcb,
                   pcsrc, regdst, memtoreg, regwrite, alucontrol, halted, illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic release_to_fetch();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1 chk("idle_outs", {13'd0, outs}, 32'd0);
        @(negedge clk);
    endtask

    // Starts at a negedge with the DUT in its first FETCH cycle; ends at the
    // negedge where the next FETCH begins. f/m are memory wait cycles for the
    // instruction fetch and for the data access.
    task automatic run_instr(input logic [2:0] op_i, input logic [3:0] funct_i,
                             input logic zero_i, input int f, input int m);
        int cyc = 0, idx = 0, cnt = 0, left = 0;
        int n_rd = 0, n_wr = 0, n_rw = 0, n_ir = 0, n_pc = 0, n_mtr = 0, n_rd1 = 0;
        int n_alu = 0, bad = 0, stall_strobe = 0;
        logic [3:0] last_alu = 4'd0;
        logic [1:0] pcsrc_or = 2'd0;
        int base, e_cyc, e_rd, e_wr, e_pc;
        op = op_i; funct = funct_i; zero = zero_i;
        while (cyc < 200) begin
            if (memread && !iord && left != 0) break;
            if (!(memread && !iord)) left = 1;
            if (memread || memwrite) begin
                if (cnt < ((idx == 0) ? f : m)) begin
                    mem_ready = 1'b0; cnt++;
                end else begin
                    mem_ready = 1'b1; cnt = 0; idx++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            n_rd  += int'(memread);
            n_wr  += int'(memwrite);
            n_rw  += int'(regwrite);
            n_ir  += int'(irwrite);
            n_pc  += int'(pcen);
            n_mtr += int'(memtoreg);
            n_rd1 += int'(regdst);
            pcsrc_or |= pcsrc;
            if (alucontrol != 4'd0) begin n_alu++; last_alu = alucontrol; end
            if ((memread && memwrite) || (regwrite && (memread || memwrite)) || halted || illegal)
                bad++;
            if (memread && !iord && !mem_ready && (irwrite || pcen)) stall_strobe++;
            cyc++;
            @(negedge clk);
        end
        case (op_i)
            3'd0: base = 4; 3'd1: base = 5; 3'd2: base = 4;
            3'd3: base = 3; 3'd4: base = 4; default: base = 3;
        endcase
        e_cyc = base + f + ((op_i == 3'd1 || op_i == 3'd2) ? m : 0);
        e_rd  = f + 1 + ((op_i == 3'd1) ? m + 1 : 0);
        e_wr  = (op_i == 3'd2) ? m + 1 : 0;
        e_pc  = 1 + ((op_i == 3'd5) ? 1 : 0) + ((op_i == 3'd3 && zero_i) ? 1 : 0);
        chk($sformatf("cycles_op%0d", op_i), cyc, e_cyc);
        chk($sformatf("memread_cyc_op%0d", op_i), n_rd, e_rd);
        chk($sformatf("memwrite_cyc_op%0d", op_i), n_wr, e_wr);
        chk($sformatf("regwrite_cyc_op%0d", op_i), n_rw,
            (op_i == 3'd0 || op_i == 3'd1 || op_i == 3'd4) ? 1 : 0);
        chk($sformatf("memtoreg_cyc_op%0d", op_i), n_mtr, (op_i == 3'd1) ? 1 : 0);
        chk($sformatf("regdst_cyc_op%0d", op_i), n_rd1, (op_i == 3'd0) ? 1 : 0);
        chk($sformatf("irwrite_cyc_op%0d", op_i), n_ir, 1);
        chk($sformatf("pcen_cyc_op%0d", op_i), n_pc, e_pc);
        chk($sformatf("pcsrc_op%0d", op_i), pcsrc_or,
            (op_i == 3'd3) ? 2'b01 : (op_i == 3'd5) ? 2'b10 : 2'b00);
        chk($sformatf("alu_val_op%0d", op_i), last_alu,
            (op_i == 3'd0) ? funct_i : (op_i == 3'd3) ? 4'b0001 : 4'b0000);
        chk($sformatf("alu_cyc_op%0d", op_i), n_alu,
            ((op_i == 3'd0 && funct_i != 4'd0) || op_i == 3'd3) ? 1 : 0);
        chk($sformatf("guarantees_op%0d", op_i), bad, 0);
        chk($sformatf("fetch_stall_strobe_op%0d", op_i), stall_strobe, 0);
    endtask

    task automatic halt_test(input logic [2:0] op_i, input logic exp_ill);
        int bad = 0;
        op = op_i; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (outs !== {17'd0, 1'b1, exp_ill}) bad++;
            @(negedge clk);
        end
        chk($sformatf("halt_hold_op%0d", op_i), bad, 0);
        #1 chk($sformatf("halt_flags_op%0d", op_i), {30'd0, halted, illegal}, {30'd0, 1'b1, exp_ill});
        #2 reset = 1'b1;
        #1 chk($sformatf("halt_reset_async_op%0d", op_i), {13'd0, outs}, 32'd0);
        release_to_fetch();
    endtask

    initial begin
        #2 chk("reset_outs", {13'd0, outs}, 32'd0);
        release_to_fetch();

        run_instr(3'b000, 4'b0101, 1'b0, 0, 0);
        run_instr(3'b001, 4'b0000, 1'b0, 0, 2);
        run_instr(3'b011, 4'b0000, 1'b1, 0, 0);
        run_instr(3'b011, 4'b0000, 1'b0, 0, 0);
        run_instr(3'b010, 4'b0000, 1'b0, 0, 0);
        run_instr(3'b101, 4'b0000, 1'b0, 0, 0);
        run_instr(3'b100, 4'b0011, 1'b1, 3, 0);

        halt_test(3'b110, 1'b1);
        halt_test(3'b111, 1'b0);

        // store stalled in MEMWR, then reset mid-wait
        op = 3'b010; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1 chk("memwr_wait", {30'd0, memwrite, iord}, 32'd3);
        @(negedge clk);
        #1 chk("memwr_hold", {31'd0, memwrite}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("memwr_reset_async", {13'd0, outs}, 32'd0);
        release_to_fetch();

        for (int i = 0; i < 40; i++) begin
            run_instr(3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle FSM controller for the 16-bit gigaHurt CPU; a shared-memory alternative to the single-cycle controller decode path.
Consumes the op/funct fields from the instruction register and the ALU zero flag.
Issues per-state control strobes to the multicycle datapath, with a ready handshake to a shared instruction/data memory.

Parameters:
n, 16, datapath width (documentation only; no port depends on it)
ALU_ADD, 4'b0000, alucontrol code for add
ALU_SUB, 4'b0001, alucontrol code for subtract

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
op  input  3  opcode: 000 R-type, 001 lw, 010 sw, 011 beq, 100 addi, 101 j, 110 reserved, 111 hlt
funct  input  4  R-type ALU function, passed straight to alucontrol
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current read/write this cycle
memread  output  1  memory read request
memwrite  output  1  memory write request
iord  output  1  memory address select: 0 PC, 1 ALUOut
irwrite  output  1  load instruction register
pcen  output  1  PC load enable = pcwrite | (branch & zero)
alusrca  output  1  ALU A select: 0 PC, 1 regA
alusrcb  output  2  ALU B select: 00 regB, 01 constant 2, 10 sign-extended imm, 11 sign-extended imm<<1
pcsrc  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target
regdst  output  1  destination register select: 1 rd, 0 rt
memtoreg  output  1  writeback data select: 1 memory data, 0 ALUOut
regwrite  output  1  register file write enable
alucontrol  output  4  ALU operation code
halted  output  1  sticky: HALT state reached
illegal  output  1  sticky: HALT was entered via opcode 110

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, HALT.
- reset (async) forces state=IDLE and clears illegal.
- In IDLE every output is 0 and alucontrol=ALU_ADD.
- IDLE -> FETCH unconditionally on the first clock after reset deasserts.
- Output rule: every output not listed for a state is 0; alucontrol defaults to ALU_ADD.
- Outputs are a Moore decode of state, except irwrite/pcwrite in FETCH and pcen in BEQEX, which are Mealy.
- pcwrite and branch are internal signals only.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH while !mem_ready; -> DECODE when mem_ready.
- DECODE: alusrca=0, alusrcb=11 (branch target into ALUOut). Next state by op:
  - 000 -> RTYPEEX
  - 001 or 010 -> MEMADR
  - 011 -> BEQEX
  - 100 -> ADDIEX
  - 101 -> JEX
  - 110 -> HALT, with illegal set
  - 111 -> HALT
- MEMADR: alusrca=1, alusrcb=10. op=001 -> MEMRD; otherwise -> MEMWR. op is stable because the IR is not written here.
- MEMRD: memread=1, iord=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: memtoreg=1, regdst=0, regwrite=1 -> FETCH.
- MEMWR: memwrite=1, iord=1. Holds until mem_ready, then -> FETCH. memwrite stays high for the entire wait.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol=funct (all 16 codes passed unmodified) -> RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=ALU_SUB, pcsrc=01, branch=1, pcen=zero -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 (pcen=1) -> FETCH.
- HALT: all strobes 0, halted=1. Terminal until reset.
- Cycle counts with mem_ready=1, FETCH through last state inclusive:
  - j, beq: 3
  - R-type, addi, sw: 4
  - lw: 5
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Guarantees:
  - memread and memwrite are never high in the same cycle.
  - regwrite is never high in the same cycle as memread or memwrite.
- Reset asserted in any state, including mid-wait in MEMWR, drops every output to its IDLE value within the same cycle (asynchronous). No partial write is held.

Test Plan:
- Reset, then R-type op=000 funct=4'b0101, mem_ready=1 -> states IDLE, FETCH, DECODE, RTYPEEX (alucontrol=0101), RTYPEWB (regwrite=1, regdst=1), FETCH; 4 cycles from FETCH.
- lw op=001 with mem_ready low for 2 cycles in MEMRD -> memread and iord held 3 cycles; MEMWB has memtoreg=1, regwrite=1; 7 cycles total.
- beq op=011 run twice, zero=1 then zero=0 -> BEQEX alucontrol=0001, pcsrc=01; pcen=1 in the first run, pcen=0 in the second.
- sw op=010, then j op=101 -> MEMWR memwrite=1, iord=1, with no regwrite; JEX pcsrc=10, pcen=1; 4 and 3 cycles.
- op=110 -> HALT with halted=1 and illegal=1, stable for 20 cycles. Then reset -> illegal=0 and the FSM restarts at IDLE. Repeat with op=111 -> halted=1, illegal=0.
- FETCH with mem_ready=0 for 3 cycles -> irwrite=0 and pcen=0 throughout. Asserting reset mid-MEMWR -> memwrite drops to 0 immediately.
